mips_mem_arbiter: RTL and testbench

//   Shares one single-port memory between the pipeline's IF port (fetch) and MEM port
//   (LW/SW). Keeps one memory transaction in flight at a time. Data has priority, and a

---
 rtl/mips_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store traffic.
// One transaction in flight; data wins unless fetch has been starved STARVE_MAX grants.
module mips_mem_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_done,
  output logic          i_stall,
  output logic          d_stall,
  output logic          busy
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  state_e        state_q;
  logic          m_en_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          discard_q;
  logic [CW-1:0] starve_cnt_q;

  logic i_elig;
  logic d_elig;
  logic starved;
  logic grant_i;
  logic grant_d;
  logic done;

  // A port acked this cycle is still showing its old request, so it is not eligible.
  always_comb begin
    d_elig  = d_req & ~d_ack_q;
    i_elig  = i_req & ~i_ack_q & ~i_flush;
    starved = (starve_cnt_q == CW'(STARVE_MAX)) & i_elig;
    grant_d = (state_q == IDLE) & d_elig & ~starved;
    grant_i = (state_q == IDLE) & i_elig & ~grant_d;
    done    = (state_q != IDLE) & ~m_en_q & m_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      m_en_q       <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      discard_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      m_en_q  <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            m_en_q    <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            state_q   <= WAIT_D;
          end else if (grant_i) begin
            m_en_q   <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= i_addr;
            state_q  <= WAIT_I;
          end
        end
        WAIT_I: begin
          if (done) begin
            state_q   <= IDLE;
            m_we_q    <= 1'b0;
            discard_q <= 1'b0;
            // A flush landing on the completion cycle still kills the fetch.
            if (!(discard_q | i_flush)) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= m_rdata;
            end
          end else if (i_flush) begin
            discard_q <= 1'b1;
          end
        end
        WAIT_D: begin
          if (done) begin
            state_q <= IDLE;
            m_we_q  <= 1'b0;
            d_ack_q <= 1'b1;
            if (!m_we_q) begin
              d_rdata_q <= m_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (!i_req || grant_i) begin
        starve_cnt_q <= '0;
      end else if (grant_d && (starve_cnt_q != CW'(STARVE_MAX))) begin
        starve_cnt_q <= starve_cnt_q + CW'(1);
      end
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);
  assign i_stall = i_req & ~i_ack_q;
  assign d_stall = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a variable-latency memory model.
module tb_mips_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_done;
  logic          i_stall;
  logic          d_stall;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int pend     = 0;
  int en_cnt   = 0;
  int iack_cnt = 0;
  int dack_cnt = 0;
  logic [DW-1:0] rd_hold;
  logic [DW-1:0] exp_ird;
  logic [DW-1:0] exp_drd;
  int e0;
  int a0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_done(m_done), .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == AW'(5)) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  // Memory answers mem_lat cycles after the m_en cycle.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_en === 1'b1) begin
      rd_hold <= mem_word(m_addr);
      if (mem_lat <= 1) begin
        m_done  <= 1'b1;
        m_rdata <= mem_word(m_addr);
        pend    <= 0;
      end else begin
        pend <= mem_lat - 1;
      end
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        m_done  <= 1'b1;
        m_rdata <= rd_hold;
      end
    end
  end

  always @(posedge clk) begin
    if (m_en === 1'b1)  en_cnt   <= en_cnt + 1;
    if (i_ack === 1'b1) iack_cnt <= iack_cnt + 1;
    if (d_ack === 1'b1) dack_cnt <= dack_cnt + 1;
  end

  assert property (@(posedge clk) (!reset && d_req && !d_ack) |=> (d_req || d_ack || reset))
    else $error("FAIL proto_d: d_req dropped before d_ack");
  assert property (@(posedge clk) (!reset && i_req && !i_ack && !i_flush) |=>
                   (i_req || i_ack || i_flush || reset))
    else $error("FAIL proto_i: i_req dropped before i_ack");

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bounded wait for an ack; sel 0 = i_ack, 1 = d_ack.
  task automatic wait_ack(input string tag, input int sel, input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      seen = (sel == 0) ? i_ack : d_ack;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    exp_ird = '0; exp_drd = '0;
    repeat (2) tick();
    check("rst_m_en",    64'(m_en), 64'd0);
    check("rst_m_we",    64'(m_we), 64'd0);
    check("rst_m_addr",  64'(m_addr), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_starve",  64'(dut.starve_cnt_q), 64'd0);
    reset = 1'b0;
    tick();

    // Single fetch, N = 1: minimum 3-cycle latency
    e0 = en_cnt; a0 = iack_cnt;
    i_req = 1'b1; i_addr = AW'(5); mem_lat = 1;
    tick();
    check("t1_m_en",    64'(m_en), 64'd1);
    check("t1_m_addr",  64'(m_addr), 64'd5);
    check("t1_i_stall", 64'(i_stall), 64'd1);
    check("t1_busy",    64'(busy), 64'd1);
    tick();
    check("t1_m_en_off", 64'(m_en), 64'd0);
    check("t1_no_ack_early", 64'(i_ack), 64'd0);
    tick();
    check("t1_i_ack",   64'(i_ack), 64'd1);
    check("t1_i_rdata", 64'(i_rdata), 64'hDEADBEEF);
    check("t1_i_stall_ack", 64'(i_stall), 64'd0);
    exp_ird = 32'hDEADBEEF;
    i_req = 1'b0;
    repeat (2) tick();
    check("t1_one_m_en", 64'(en_cnt - e0), 64'd1);
    check("t1_one_ack",  64'(iack_cnt - a0), 64'd1);

    // Simultaneous fetch and load: data first, no re-grant of the stale d_req
    e0 = en_cnt;
    i_req = 1'b1; i_addr = AW'(16); d_req = 1'b1; d_we = 1'b0; d_addr = AW'(9);
    tick();
    check("t2_d_first", 64'(m_addr), 64'd9);
    check("t2_d_load",  64'(m_we), 64'd0);
    check("t2_d_stall", 64'(d_stall), 64'd1);
    repeat (2) tick();
    check("t2_d_ack",   64'(d_ack), 64'd1);
    check("t2_d_rdata", 64'(d_rdata), 64'(mem_word(AW'(9))));
    exp_drd = mem_word(AW'(9));
    d_req = 1'b0;
    tick();
    check("t2_i_grant", 64'(m_en), 64'd1);
    check("t2_i_addr",  64'(m_addr), 64'd16);
    check("t2_starve_clr", 64'(dut.starve_cnt_q), 64'd0);
    repeat (2) tick();
    check("t2_i_ack",   64'(i_ack), 64'd1);
    check("t2_i_rdata", 64'(i_rdata), 64'(mem_word(AW'(16))));
    exp_ird = mem_word(AW'(16));
    i_req = 1'b0;
    tick();
    check("t2_two_m_en", 64'(en_cnt - e0), 64'd2);

    // Starvation bound: 4 D grants while fetch pends, then fetch wins over a ready load
    i_req = 1'b1; i_addr = AW'(32); i_flush = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(256);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_d_grant", 64'(m_en), 64'd1);
      check("t3_d_addr",  64'(m_addr), 64'(256 + k));
      repeat (2) tick();
      check("t3_d_ack",   64'(d_ack), 64'd1);
      check("t3_d_rdata", 64'(d_rdata), 64'(mem_word(AW'(256 + k))));
      exp_drd = mem_word(AW'(256 + k));
      d_addr = AW'(257 + k);
      tick();
      if (k == 3) begin
        check("t3_starve_max", 64'(dut.starve_cnt_q), 64'(SM));
        i_flush = 1'b0;
      end
    end
    tick();
    check("t3_i_wins",   64'(m_en), 64'd1);
    check("t3_i_addr",   64'(m_addr), 64'd32);
    check("t3_starve_0", 64'(dut.starve_cnt_q), 64'd0);
    repeat (2) tick();
    check("t3_i_ack",    64'(i_ack), 64'd1);
    check("t3_i_rdata",  64'(i_rdata), 64'(mem_word(AW'(32))));
    exp_ird = mem_word(AW'(32));
    i_req = 1'b0;
    wait_ack("t3_d_after_i", 1, 8);
    check("t3_d5_rdata", 64'(d_rdata), 64'(mem_word(AW'(260))));
    exp_drd = mem_word(AW'(260));
    d_req = 1'b0;
    tick();
    check("t3_starve_end", 64'(dut.starve_cnt_q), 64'd0);

    // Flush one cycle into WAIT_I with N = 3: fetch data dropped
    a0 = iack_cnt; mem_lat = 3;
    i_req = 1'b1; i_addr = AW'(48);
    tick();
    check("t4_m_en", 64'(m_en), 64'd1);
    i_flush = 1'b1; i_req = 1'b0;
    tick();
    i_flush = 1'b0;
    check("t4_busy_wait", 64'(busy), 64'd1);
    repeat (2) tick();
    check("t4_busy_done_cyc", 64'(busy), 64'd1);
    tick();
    check("t4_busy_drop", 64'(busy), 64'd0);
    check("t4_no_ack",    64'(i_ack), 64'd0);
    check("t4_rdata_held", 64'(i_rdata), 64'(exp_ird));
    tick();
    check("t4_ack_count", 64'(iack_cnt - a0), 64'd0);
    mem_lat = 1;
    i_req = 1'b1; i_addr = AW'(64);
    wait_ack("t4_next_ack", 0, 8);
    check("t4_next_rdata", 64'(i_rdata), 64'(mem_word(AW'(64))));
    exp_ird = mem_word(AW'(64));
    i_req = 1'b0;
    tick();

    // Store to the top address
    d_req = 1'b1; d_we = 1'b1; d_addr = AW'(1023); d_wdata = 32'h1234;
    tick();
    check("t5_m_en",    64'(m_en), 64'd1);
    check("t5_m_we",    64'(m_we), 64'd1);
    check("t5_m_addr",  64'(m_addr), 64'h3FF);
    check("t5_m_wdata", 64'(m_wdata), 64'h1234);
    repeat (2) tick();
    check("t5_d_ack",   64'(d_ack), 64'd1);
    check("t5_d_rdata_kept", 64'(d_rdata), 64'(exp_drd));
    check("t5_m_we_clr", 64'(m_we), 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Reset during WAIT_D; the late m_done must not produce an ack
    a0 = dack_cnt; mem_lat = 2;
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(119);
    tick();
    check("t6_m_en", 64'(m_en), 64'd1);
    reset = 1'b1; d_req = 1'b0;
    tick();
    check("t6_m_en_rst",   64'(m_en), 64'd0);
    check("t6_busy_rst",   64'(busy), 64'd0);
    check("t6_m_addr_rst", 64'(m_addr), 64'd0);
    check("t6_m_wdata_rst", 64'(m_wdata), 64'd0);
    check("t6_i_rdata_rst", 64'(i_rdata), 64'd0);
    check("t6_d_rdata_rst", 64'(d_rdata), 64'd0);
    reset = 1'b0;
    e0 = en_cnt;
    repeat (3) tick();
    check("t6_no_ack",    64'(dack_cnt - a0), 64'd0);
    check("t6_no_m_en",   64'(en_cnt - e0), 64'd0);
    check("t6_d_rdata",   64'(d_rdata), 64'd0);
    check("t6_busy_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
